uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Parametrised UART receiver, the successor to the fixed 8N1 receiver. It supports 5–9 data bits, none/odd/even parity, 1 or 2 stop bits, and 3-sample majority voting at bit centre. It also reports framing, parity and overrun errors. It sits between the asynchronous `rx` pin and the on-chip byte consumer, delivering each frame through a valid/ready handshake.

## Interface
- `CLK_FREQ`, default 5_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate. `DIV = CLK_FREQ/BAUD_RATE` (integer, truncated); must be ≥ 16.
- `DATA_BITS`, default 8: data bits per frame, legal 5..9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `clk`  in  1: sole clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `rx`  in  1: asynchronous serial line, idle high.
- `m_data`  out  DATA_BITS: received word, LSB = first bit on the line.
- `m_valid`  out  1: `m_data` and the error flags are valid.
- `m_ready`  in  1: consumer accepts the word when `m_valid && m_ready`.
- `frame_err`  out  1: a stop bit sampled 0; qualified by `m_valid`.
- `parity_err`  out  1: parity mismatch; qualified by `m_valid`; always 0 when `PARITY == 0`.
- `overrun`  out  1: one-cycle pulse when a completed frame is dropped.
- `busy`  out  1: high from start-edge detection until the last stop-bit sample.

## Operation
- **Input conditioning**
  - `rx` passes through a 2-flop synchroniser plus one history flop. All three reset to 1, so a line held low through reset never starts a frame.
  - Majority value at a sample point = 2-of-3 vote over the last three synchronised samples.
- **States:** IDLE, START, DATA, PARITY, STOP, and a 2-bit encoding of the stop index.
- **Bit-timing counter:** width `$clog2(DIV)`. Cleared on entering START; cleared again at every sample point.
- **IDLE**
  - A 1→0 transition on the synchronised line moves to START and sets `busy`.
- **START**
  - At `cnt == DIV/2-1`, take the vote.
  - Vote 1 → false start; return to IDLE and drop `busy`.
  - Vote 0 → go to DATA.
- **DATA**
  - Sample at `cnt == DIV-1`.
  - Shift right into a `DATA_BITS` shift register; bit index counts 0..DATA_BITS-1.
  - After the last bit, go to PARITY if `PARITY != 0`, else STOP.
- **PARITY**
  - One sample.
  - Mismatch = (XOR of data bits ^ sampled bit) != (PARITY == 1).
- **STOP**
  - `STOP_BITS` samples. Any 0 sets the frame-error bit, but all stop bits are still sampled.
  - After the final stop sample: go to IDLE, drop `busy`, assert a one-cycle internal `done`.
  - Returning to IDLE at mid-stop-bit allows back-to-back frames.
- **Output register**
  - On `done` with `!m_valid` or `m_ready`: load `m_data`, `frame_err`, `parity_err`; set `m_valid`.
  - On `done` with `m_valid && !m_ready`: keep the old word, pulse `overrun` for one cycle, discard the new frame.
  - `m_ready` with no `done`: clear `m_valid`. Data and flags hold their last value.
- **Break** (line low for a whole frame): delivered as `m_data = 0`, `frame_err = 1`. The receiver then waits in IDLE for a high→low edge.
- **Reset, at any time:** returns to IDLE; clears the shift register, counters and `busy`; drops the in-flight frame.

## Timing
- **Reset values:** `m_data = 0`, `m_valid = 0`, `frame_err = 0`, `parity_err = 0`, `overrun = 0`, `busy = 0`.
- **Start detection:** `busy` rises 3 clocks after the `rx` falling edge (2 sync + 1 edge-detect register).
- **Sample points:** start at `DIV/2` clocks after `busy` rises; each later bit exactly `DIV` clocks after the previous sample.
- **Output latency:** `m_valid`, `m_data` and the flags update on the clock edge after the final stop-bit sample. `overrun` pulses on that same edge.
- **Handshake:** `m_valid` falls on the edge after the `m_valid && m_ready` cycle. A simultaneous accept and `done` leaves `m_valid` high with new data and no `overrun`.
- **Hold rule:** `m_data` and the flags must not change while `m_valid && !m_ready`.

## Structure
- **Shared package `uart_pkg`:**
  - parity-mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the receive state enum;
  - a constant function `baud_div(clk, baud)`.
  - The transmitter successor reuses this package.
- **Sub-module `uart_rx_sampler`:** synchroniser, history flop, edge detect and majority vote. Outputs: `fall`, `vote`.
- The FSM, counters and output register stay in `uart_rx_frame`.

## Test plan
All scenarios use defaults (`DIV = 520`) unless stated.
1. **8N1:** send 0xA5. `m_valid` rises; `m_data = 0xA5`; both error flags 0; `m_valid` held until `m_ready`, then cleared the next cycle.
2. **`PARITY = 2`, `DATA_BITS = 7`:** send 0x55 with correct parity → `parity_err = 0`. Resend with parity flipped → `m_data = 0x55`, `parity_err = 1`.
3. **`STOP_BITS = 2`:** send 0x3C with the second stop bit 0 → `frame_err = 1`, `m_data = 0x3C`. Then a 40-bit-time low break → `m_data = 0x00`, `frame_err = 1`, and the next frame is clean.
4. **Noise and false start:**
   - 1-clock low glitch on the idle line → no frame.
   - Low pulse of 100 clocks → START aborts, `busy` falls, no `m_valid`.
   - Single-clock inversion at a data-bit centre → correct byte (majority vote).
5. **Overrun:** hold `m_ready = 0` and send 0x11 then 0x22 back-to-back → `m_data` stays 0x11 and `overrun` pulses once. Send 0x33 with `m_ready` asserted in the `done` cycle → 0x33 loaded, no pulse.
6. **Reset mid-frame:** assert `rst_n = 0` during DATA bit 4 with `rx` held low → all outputs 0. With `rx` still low after release, no frame starts until a high→low edge; a following 0x7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receive state encoding and baud divisor.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning for the UART receiver: synchroniser, history flop,
// start-edge detect and 2-of-3 majority vote.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic fall,
    output logic vote
);

    logic       sync1;
    logic       sync2;
    logic       hist;
    logic [1:0] fill;
    logic       armed;

    // The chain resets high, so the first real low sample would look like an
    // edge; edges only count once a genuine high has come through sync2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            hist  <= sync2;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & sync2);
        end
    end

    assign fall = armed & hist & ~sync2;
    assign vote = (sync1 & sync2) | (sync1 & hist) | (sync2 & hist);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: 5..9 data bits, optional parity, 1/2 stop bits,
// frame/parity/overrun reporting and a valid/ready output register.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 5_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy,
    output rx_state_e            state_dbg
);

    localparam int DIV  = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int CW   = $clog2(DIV);
    localparam int HALF = DIV / 2;

    // m_valid/m_ready: a word transfers in any cycle where both are high;
    // while m_valid && !m_ready the data and flags are frozen.

    logic                 fall;
    logic                 vote;
    rx_state_e            state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [1:0]           stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 done;

    uart_rx_sampler u_sampler (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .fall  (fall),
        .vote  (vote)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= '0;
            shreg    <= '0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (fall) begin
                        state <= RX_START;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == CW'(HALF - 1)) begin
                        cnt <= '0;
                        if (vote) begin
                            state <= RX_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= RX_DATA;
                            bit_idx  <= '0;
                            stop_idx <= '0;
                            perr_r   <= 1'b0;
                            ferr_r   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CW'(DIV - 1)) begin
                        cnt   <= '0;
                        shreg <= {vote, shreg[DATA_BITS-1:1]};
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (cnt == CW'(DIV - 1)) begin
                        cnt    <= '0;
                        perr_r <= ((^shreg) ^ vote) != (PARITY == PAR_ODD);
                        state  <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CW'(DIV - 1)) begin
                        cnt <= '0;
                        if (!vote) begin
                            ferr_r <= 1'b1;
                        end
                        // Leaving at mid-stop-bit lets the next start edge be caught.
                        if (stop_idx == 2'(STOP_BITS - 1)) begin
                            state <= RX_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            stop_idx <= stop_idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!m_valid || m_ready) begin
                    m_data     <= shreg;
                    frame_err  <= ferr_r;
                    parity_err <= perr_r;
                    m_valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: four instances (8N1, 7E1, 8N2, fast 9O2) exercised
// in parallel by directed sequences, a vector table and a randomised scoreboard.
module tb_uart_rx_frame;
    import uart_pkg::*;

    localparam int DIV_D = 520;
    localparam int DIV_F = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rx_v;
    logic [3:0] rst_v;
    logic [2:0] rdy_v;
    logic       rdy_f = 1'b0;

    logic [7:0] d_a;  logic v_a, fe_a, pe_a, ov_a, bz_a;  rx_state_e st_a;
    logic [6:0] d_b;  logic v_b, fe_b, pe_b, ov_b, bz_b;  rx_state_e st_b;
    logic [7:0] d_c;  logic v_c, fe_c, pe_c, ov_c, bz_c;  rx_state_e st_c;
    logic [8:0] d_f;  logic v_f, fe_f, pe_f, ov_f, bz_f;  rx_state_e st_f;

    int errors = 0;
    int checks = 0;
    int ovr_cnt_a = 0;
    int ovr_cnt_f = 0;
    logic [10:0] exp_q[$];

    uart_rx_frame dut_a (
        .clk(clk), .rst_n(rst_v[0]), .rx(rx_v[0]), .m_data(d_a), .m_valid(v_a),
        .m_ready(rdy_v[0]), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a),
        .busy(bz_a), .state_dbg(st_a)
    );
    uart_rx_frame #(.DATA_BITS(7), .PARITY(PAR_EVEN)) dut_b (
        .clk(clk), .rst_n(rst_v[1]), .rx(rx_v[1]), .m_data(d_b), .m_valid(v_b),
        .m_ready(rdy_v[1]), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b),
        .busy(bz_b), .state_dbg(st_b)
    );
    uart_rx_frame #(.STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_v[2]), .rx(rx_v[2]), .m_data(d_c), .m_valid(v_c),
        .m_ready(rdy_v[2]), .frame_err(fe_c), .parity_err(pe_c), .overrun(ov_c),
        .busy(bz_c), .state_dbg(st_c)
    );
    uart_rx_frame #(.CLK_FREQ(1_000_000), .BAUD_RATE(62_500), .DATA_BITS(9),
                    .PARITY(PAR_ODD), .STOP_BITS(2)) dut_f (
        .clk(clk), .rst_n(rst_v[3]), .rx(rx_v[3]), .m_data(d_f), .m_valid(v_f),
        .m_ready(rdy_f), .frame_err(fe_f), .parity_err(pe_f), .overrun(ov_f),
        .busy(bz_f), .state_dbg(st_f)
    );

    always @(negedge clk) begin
        if (ov_a === 1'b1) ovr_cnt_a++;
        if (ov_f === 1'b1) ovr_cnt_f++;
    end

    initial begin
        #990_000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic get_out(input int inst, output logic [8:0] d, output logic v,
                           output logic fe, output logic pe, output logic bz);
        case (inst)
            0:       begin d = {1'b0, d_a}; v = v_a; fe = fe_a; pe = pe_a; bz = bz_a; end
            1:       begin d = {2'b0, d_b}; v = v_b; fe = fe_b; pe = pe_b; bz = bz_b; end
            2:       begin d = {1'b0, d_c}; v = v_c; fe = fe_c; pe = pe_c; bz = bz_c; end
            default: begin d = d_f;         v = v_f; fe = fe_f; pe = pe_f; bz = bz_f; end
        endcase
    endtask

    task automatic check_frame(input int inst, input string name, input logic [8:0] ed,
                               input bit epe, input bit efe);
        logic [8:0] d; logic v, fe, pe, bz;
        get_out(inst, d, v, fe, pe, bz);
        check({name, "_valid"}, v, 1);
        check({name, "_data"}, d, ed);
        check({name, "_perr"}, pe, epe);
        check({name, "_ferr"}, fe, efe);
    endtask

    task automatic wait_valid(input int inst, input int budget, input string name);
        logic [8:0] d; logic v, fe, pe, bz;
        for (int i = 0; i < budget; i++) begin
            get_out(inst, d, v, fe, pe, bz);
            if (v) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s m_valid actual=0 required=1 within %0d cycles", name, budget);
    endtask

    task automatic wait_bz(input int inst, input logic level, input int budget, input string name);
        logic [8:0] d; logic v, fe, pe, bz;
        for (int i = 0; i < budget; i++) begin
            get_out(inst, d, v, fe, pe, bz);
            if (bz == level) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s busy actual=%0b required=%0b within %0d cycles", name, ~level, level, budget);
    endtask

    task automatic accept(input int inst, input string name);
        logic [8:0] d; logic v, fe, pe, bz;
        rdy_v[inst] = 1'b1;
        @(negedge clk);
        rdy_v[inst] = 1'b0;
        get_out(inst, d, v, fe, pe, bz);
        check({name, "_accept_clears"}, v, 0);
    endtask

    // ---------------- line drivers (called on a falling clock edge) ----------------
    task automatic drive_bit(input int inst, input int div, input logic b, input bit glitch);
        rx_v[inst] = b;
        if (glitch) begin
            repeat (div / 2) @(negedge clk);
            rx_v[inst] = ~b;
            @(negedge clk);
            rx_v[inst] = b;
            repeat (div - div / 2 - 1) @(negedge clk);
        end else begin
            repeat (div) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int inst, input int div, input logic [8:0] data,
                              input int nbits, input bit has_par, input bit pbit,
                              input int stops, input logic [1:0] bad, input int glitch);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
        if (has_par) bits.push_back(pbit);
        for (int i = 0; i < stops; i++) bits.push_back(~bad[i]);
        foreach (bits[k]) drive_bit(inst, div, bits[k], k == glitch);
        rx_v[inst] = 1'b1;
    endtask

    function automatic bit par_bit(input logic [8:0] data, input int nbits, input int mode);
        int ones;
        ones = 0;
        for (int i = 0; i < nbits; i++) ones += int'(data[i]);
        return (mode == PAR_EVEN) ? bit'(ones % 2) : bit'(1 - ones % 2);
    endfunction

    // ---------------- 8N1 directed sequences ----------------
    task automatic run_a;
        int snap;
        repeat (100) @(negedge clk);
        check("low_through_reset_busy", bz_a, 0);
        rx_v[0] = 1'b1;
        repeat (DIV_D) @(negedge clk);

        send_frame(0, DIV_D, 9'h0A5, 8, 0, 0, 1, 2'b00, -1);
        wait_valid(0, DIV_D, "a5");
        check_frame(0, "a5", 9'h0A5, 0, 0);
        repeat (50) @(negedge clk);
        check("a5_hold_valid", v_a, 1);
        check("a5_hold_data", d_a, 8'hA5);
        accept(0, "a5");

        rx_v[0] = 1'b0;
        @(negedge clk);
        rx_v[0] = 1'b1;
        repeat (DIV_D) @(negedge clk);
        check("glitch_no_valid", v_a, 0);
        check("glitch_busy_low", bz_a, 0);

        rx_v[0] = 1'b0;
        repeat (100) @(negedge clk);
        rx_v[0] = 1'b1;
        check("pulse100_busy_high", bz_a, 1);
        repeat (DIV_D) @(negedge clk);
        check("pulse100_busy_low", bz_a, 0);
        check("pulse100_no_valid", v_a, 0);

        send_frame(0, DIV_D, 9'h096, 8, 0, 0, 1, 2'b00, 3);
        wait_valid(0, DIV_D, "vote");
        check_frame(0, "vote", 9'h096, 0, 0);
        accept(0, "vote");

        snap = ovr_cnt_a;
        send_frame(0, DIV_D, 9'h011, 8, 0, 0, 1, 2'b00, -1);
        send_frame(0, DIV_D, 9'h022, 8, 0, 0, 1, 2'b00, -1);
        repeat (4) @(negedge clk);
        check_frame(0, "ovr_keep11", 9'h011, 0, 0);
        check("ovr_pulse_count", ovr_cnt_a - snap, 1);

        snap = ovr_cnt_a;
        fork
            send_frame(0, DIV_D, 9'h033, 8, 0, 0, 1, 2'b00, -1);
            begin
                wait_bz(0, 1'b1, 20, "ovr33_busy_rise");
                wait_bz(0, 1'b0, 11 * DIV_D, "ovr33_busy_fall");
                rdy_v[0] = 1'b1;
                @(negedge clk);
                check("ovr33_valid", v_a, 1);
                check("ovr33_data", d_a, 8'h33);
                @(negedge clk);
                rdy_v[0] = 1'b0;
                check("ovr33_accept_clears", v_a, 0);
            end
        join
        repeat (4) @(negedge clk);
        check("ovr33_no_pulse", ovr_cnt_a - snap, 0);

        drive_bit(0, DIV_D, 1'b0, 0);
        for (int i = 0; i < 4; i++) drive_bit(0, DIV_D, 1'b1, 0);
        rx_v[0] = 1'b0;
        repeat (DIV_D / 2) @(negedge clk);
        check("rst_in_data_state", st_a, RX_DATA);
        rst_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_data", d_a, 0);
        check("rst_mid_valid", v_a, 0);
        check("rst_mid_flags", {fe_a, pe_a, ov_a}, 0);
        check("rst_mid_busy", bz_a, 0);
        rst_v[0] = 1'b1;
        repeat (2 * DIV_D) @(negedge clk);
        check("rst_low_line_busy", bz_a, 0);
        check("rst_low_line_valid", v_a, 0);
        rx_v[0] = 1'b1;
        repeat (DIV_D) @(negedge clk);
        send_frame(0, DIV_D, 9'h07E, 8, 0, 0, 1, 2'b00, -1);
        wait_valid(0, DIV_D, "after_rst");
        check_frame(0, "after_rst", 9'h07E, 0, 0);
        accept(0, "after_rst");
    endtask

    // ---------------- 7E1 / 8N2 vector table and break ----------------
    typedef struct {
        int         inst;
        logic [8:0] data;
        bit         flip;
        logic [1:0] bad;
        logic [8:0] exp_d;
        bit         exp_pe;
        bit         exp_fe;
    } vec_t;

    task automatic run_bc;
        vec_t vt[6];
        vt[0] = '{1, 9'h055, 1'b0, 2'b00, 9'h055, 1'b0, 1'b0};
        vt[1] = '{1, 9'h055, 1'b1, 2'b00, 9'h055, 1'b1, 1'b0};
        vt[2] = '{1, 9'h02B, 1'b0, 2'b00, 9'h02B, 1'b0, 1'b0};
        vt[3] = '{2, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1};
        vt[4] = '{2, 9'h0C3, 1'b0, 2'b01, 9'h0C3, 1'b0, 1'b1};
        vt[5] = '{2, 9'h0FF, 1'b0, 2'b00, 9'h0FF, 1'b0, 1'b0};
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            int  nb;
            bit  pb;
            nb = (vt[i].inst == 1) ? 7 : 8;
            pb = par_bit(vt[i].data, nb, PAR_EVEN) ^ vt[i].flip;
            send_frame(vt[i].inst, DIV_D, vt[i].data, nb, vt[i].inst == 1, pb,
                       (vt[i].inst == 2) ? 2 : 1, vt[i].bad, -1);
            wait_valid(vt[i].inst, DIV_D, $sformatf("vec%0d", i));
            check_frame(vt[i].inst, $sformatf("vec%0d", i), vt[i].exp_d, vt[i].exp_pe, vt[i].exp_fe);
            accept(vt[i].inst, $sformatf("vec%0d", i));
            repeat (DIV_D / 4) @(negedge clk);
        end

        fork
            begin
                rx_v[2] = 1'b0;
                repeat (40 * DIV_D) @(negedge clk);
                rx_v[2] = 1'b1;
            end
            begin
                wait_valid(2, 20 * DIV_D, "break");
                check_frame(2, "break", 9'h000, 0, 1);
                accept(2, "break");
            end
        join
        check("break_single_frame", v_c, 0);
        repeat (DIV_D) @(negedge clk);
        send_frame(2, DIV_D, 9'h05A, 8, 0, 0, 2, 2'b00, -1);
        wait_valid(2, DIV_D, "post_break");
        check_frame(2, "post_break", 9'h05A, 0, 0);
        accept(2, "post_break");
    endtask

    // ---------------- fast 9O2 randomised run ----------------
    task automatic run_f;
        bit sending_done;
        sending_done = 1'b0;
        fork
            begin
                repeat (20) @(negedge clk);
                for (int i = 0; i < 60; i++) begin
                    logic [8:0] data;
                    logic [1:0] bad;
                    bit         pb;
                    bit         epe;
                    int         ones;
                    int         gl;
                    data = 9'($urandom_range(0, 511));
                    pb   = par_bit(data, 9, PAR_ODD) ^ ($urandom_range(0, 3) == 0);
                    bad  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                    gl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
                    ones = $countones(data) + int'(pb);
                    epe  = (ones % 2) == 0;
                    exp_q.push_back({|bad, epe, data});
                    send_frame(3, DIV_F, data, 9, 1, pb, 2, bad, gl);
                    repeat ($urandom_range(0, 20)) @(negedge clk);
                end
                repeat (4 * DIV_F) @(negedge clk);
                sending_done = 1'b1;
            end
            begin
                while (!sending_done) begin
                    @(posedge clk);
                    #2 rdy_f = 1'($urandom_range(0, 1));
                end
            end
            begin
                while (!sending_done) begin
                    @(negedge clk);
                    if (v_f && rdy_f) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rand_unexpected actual=0x%0h required=no frame", {fe_f, pe_f, d_f});
                        end else begin
                            check("rand_frame", {fe_f, pe_f, d_f}, exp_q.pop_front());
                        end
                    end
                end
            end
        join
        check("rand_all_delivered", exp_q.size(), 0);
        check("rand_no_overrun", ovr_cnt_f, 0);
    endtask

    initial begin
        rx_v  = 4'b1110;
        rdy_v = 3'b000;
        rst_v = 4'b0000;
        repeat (5) @(negedge clk);
        check("reset_data", d_a, 0);
        check("reset_valid", {v_a, v_b, v_c, v_f}, 0);
        check("reset_ferr", {fe_a, fe_b, fe_c, fe_f}, 0);
        check("reset_perr", {pe_a, pe_b, pe_c, pe_f}, 0);
        check("reset_overrun", {ov_a, ov_b, ov_c, ov_f}, 0);
        check("reset_busy", {bz_a, bz_b, bz_c, bz_f}, 0);
        check("reset_state", {st_a, st_b, st_c, st_f}, {RX_IDLE, RX_IDLE, RX_IDLE, RX_IDLE});
        check("reset_data_bcf", {d_b, d_c, d_f}, 0);
        rst_v = 4'b1111;
        fork
            run_a;
            run_bc;
            run_f;
        join
        check("end_no_overrun_bc", {ov_b, ov_c}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
